// File: rtl/coeff_load_ctrl.sv
// coeff_load_ctrl: host-side loader that turns a coefficient stream into FIR coefficient-RAM writes.
// Latency: write strobe one cycle after the accepting edge; one word per 2 cycles (3 with mirroring).
// Backpressure: oReady is low outside WAIT and in the first WAIT cycle of a session; iValid gaps hold WAIT.
// Optional macro COEFF_SYM_EN: stream taps 0..NUM_TAP/2-1 only and mirror each write to tap NUM_TAP-1-k.
module coeff_load_ctrl #(
  parameter int NUM_MODULE = 4,
  parameter int NUM_TAP    = 10,
  parameter int DW         = 16
) (
  input  logic          iClk12M,
  input  logic          iRsn,
  input  logic          iStart,
  input  logic          iValid,
  input  logic [DW-1:0] iCoeff,
  output logic          oReady,
  output logic          oCoeffUpdateFlag,
  output logic          oCsnRam,
  output logic          oWrnRam,
  output logic [5:0]    oAddrRam,
  output logic [DW-1:0] oWtDtRam,
  output logic          oBusy,
  output logic          oDone
);

  localparam logic [3:0] TAP_LAST = 4'(NUM_TAP - 1);
  localparam logic [1:0] MOD_LAST = 2'(NUM_MODULE - 1);
`ifdef COEFF_SYM_EN
  // Only the first half of each module's taps is streamed; the rest are mirrored.
  localparam logic [3:0] TAP_STREAM_LAST = 4'(NUM_TAP / 2 - 1);
`else
  localparam logic [3:0] TAP_STREAM_LAST = TAP_LAST;
`endif

`ifdef COEFF_SYM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_WRITE, S_MIRROR, S_FLUSH, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_WRITE, S_FLUSH, S_DONE
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [3:0]    tap_q, tap_d;
  logic [1:0]    mod_q, mod_d;

  logic          ready_q, ready_d;
  logic          flag_q, flag_d;
  logic          csn_q, csn_d;
  logic          wrn_q, wrn_d;
  logic [5:0]    addr_q, addr_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          xfer;
  logic          row_end;
  logic          sess_end;
  logic [3:0]    tap_adv;
  logic [1:0]    mod_adv;

  assign xfer     = iValid && ready_q;
  assign row_end  = (tap_q == TAP_STREAM_LAST);
  assign sess_end = row_end && (mod_q == MOD_LAST);
  assign tap_adv  = row_end ? 4'd0 : tap_q + 4'd1;
  assign mod_adv  = row_end ? mod_q + 2'd1 : mod_q;

  // Next-state and next-output decode; every output is registered below.
  // The first WAIT cycle of a session keeps oReady low so that a word
  // presented together with iStart is never taken; later WAITs are ready at once.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    mod_d   = mod_q;
    ready_d = 1'b0;
    flag_d  = flag_q;
    csn_d   = 1'b1;
    wrn_d   = 1'b1;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        flag_d = 1'b0;
        busy_d = 1'b0;
        if (iStart) begin
          state_d = S_WAIT;
          tap_d   = 4'd0;
          mod_d   = 2'd0;
          flag_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_WAIT: begin
        if (xfer) begin
          state_d = S_WRITE;
          wdat_d  = iCoeff;
          addr_d  = {mod_q, tap_q};
          csn_d   = 1'b0;
          wrn_d   = 1'b0;
        end else begin
          ready_d = 1'b1;
        end
      end
`ifdef COEFF_SYM_EN
      S_WRITE: begin
        // Second strobe of the same word to the symmetric tap.
        state_d = S_MIRROR;
        addr_d  = {mod_q, TAP_LAST - tap_q};
        csn_d   = 1'b0;
        wrn_d   = 1'b0;
      end
      S_MIRROR: begin
        tap_d = tap_adv;
        mod_d = mod_adv;
        if (sess_end) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_WAIT;
          ready_d = 1'b1;
        end
      end
`else
      S_WRITE: begin
        tap_d = tap_adv;
        mod_d = mod_adv;
        if (sess_end) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_WAIT;
          ready_d = 1'b1;
        end
      end
`endif
      S_FLUSH: begin
        // Flag stays up through this idle cycle so the FIR FSM sees the last write.
        state_d = S_DONE;
        flag_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        addr_d  = 6'd0;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge iClk12M) begin
    if (iRsn) begin
      state_q <= S_IDLE;
      tap_q   <= 4'd0;
      mod_q   <= 2'd0;
      ready_q <= 1'b0;
      flag_q  <= 1'b0;
      csn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      addr_q  <= 6'd0;
      wdat_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      mod_q   <= mod_d;
      ready_q <= ready_d;
      flag_q  <= flag_d;
      csn_q   <= csn_d;
      wrn_q   <= wrn_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign oReady           = ready_q;
  assign oCoeffUpdateFlag = flag_q;
  assign oCsnRam          = csn_q;
  assign oWrnRam          = wrn_q;
  assign oAddrRam         = addr_q;
  assign oWtDtRam         = wdat_q;
  assign oBusy            = busy_q;
  assign oDone            = done_q;

endmodule

// File: tb/tb_coeff_load_ctrl.sv
// tb_coeff_load_ctrl: directed sessions for coeff_load_ctrl with a write scoreboard.
// Expected {addr,data} pairs are queued at stimulus time and popped on each write strobe.
// Also tracks transfers, done pulses and flag high time per session.
module tb_coeff_load_ctrl;

  localparam int NM = 4;
  localparam int NT = 10;
  localparam int DW = 16;
`ifdef COEFF_SYM_EN
  localparam int CPS     = NM * NT / 2;
  localparam int STEP    = 3;
  localparam int ABORT_N = 9;
`else
  localparam int CPS     = NM * NT;
  localparam int STEP    = 2;
  localparam int ABORT_N = 17;
`endif
  localparam int LIMIT = 300;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          valid;
  logic [DW-1:0] coeff;
  logic          ready;
  logic          flag;
  logic          csn;
  logic          wrn;
  logic [5:0]    addr;
  logic [DW-1:0] wdat;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [21:0] exp_q[$];
  int xfer_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int flag_len = 0;
  logic flag_prev = 1'b0;
  int exp_flag_len = 0;

  coeff_load_ctrl #(.NUM_MODULE(NM), .NUM_TAP(NT), .DW(DW)) dut (
    .iClk12M          (clk),
    .iRsn             (rst),
    .iStart           (start),
    .iValid           (valid),
    .iCoeff           (coeff),
    .oReady           (ready),
    .oCoeffUpdateFlag (flag),
    .oCsnRam          (csn),
    .oWrnRam          (wrn),
    .oAddrRam         (addr),
    .oWtDtRam         (wdat),
    .oBusy            (busy),
    .oDone            (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the RAM write(s) that coefficient number idx of a session must produce.
  task automatic push_exp(input int idx, input logic [DW-1:0] d);
    int m;
    int k;
`ifdef COEFF_SYM_EN
    m = idx / (NT / 2);
    k = idx % (NT / 2);
    exp_q.push_back({2'(m), 4'(k), d});
    exp_q.push_back({2'(m), 4'(NT - 1 - k), d});
`else
    m = idx / NT;
    k = idx % NT;
    exp_q.push_back({2'(m), 4'(k), d});
`endif
  endtask

  // Present one word after gap idle cycles and return just after its transfer edge.
  task automatic send(input int idx, input logic [DW-1:0] d, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      valid = 1'b0;
      tick();
    end
    valid = 1'b1;
    coeff = d;
    push_exp(idx, d);
    n = 0;
    while (!ready && n < LIMIT) begin
      tick();
      n++;
    end
    if (n >= LIMIT) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no oReady in %0d cycles, required oReady=1", LIMIT);
    end
    tick();
  endtask

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < LIMIT) begin
      tick();
      n++;
    end
    check(name, done, 1'b1);
  endtask

  // Monitor: scoreboard pops, strobe sanity, transfer/done counts, flag high time.
  always @(negedge clk) begin
    logic [21:0] e;
    if (rst) begin
      flag_len  = 0;
      flag_prev = 1'b0;
    end else begin
      if (valid && ready) xfer_cnt++;
      if (!csn || !wrn) check("csn_wrn_pair", {30'd0, csn, wrn}, 32'd0);
      if (!csn) begin
        wr_cnt++;
`ifdef COEFF_SYM_EN
        check("wr_after_xfer", (wr_cnt > 2 * xfer_cnt), 1'b0);
`else
        check("wr_after_xfer", (wr_cnt > xfer_cnt), 1'b0);
`endif
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got write addr 0x%0h data 0x%0h, required no write", addr, wdat);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", addr, e[21:16]);
          check("wr_data", wdat, e[15:0]);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_addr", addr, 6'd0);
        check("done_flag", flag, 1'b0);
      end
      if (flag) begin
        flag_len++;
      end else if (flag_prev) begin
        if (exp_flag_len != 0) check("flag_len", flag_len, exp_flag_len);
        flag_len = 0;
      end
      flag_prev = flag;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of run, required $finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int x0;
    int d0;
    int n;
    rst   = 1'b1;
    start = 1'b0;
    valid = 1'b0;
    coeff = '0;
    repeat (3) tick();

    // Reset values.
    check("rst_ready", ready, 1'b0);
    check("rst_flag", flag, 1'b0);
    check("rst_csn", csn, 1'b1);
    check("rst_wrn", wrn, 1'b1);
    check("rst_addr", addr, 6'd0);
    check("rst_wdat", wdat, 16'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    tick();

    // Full load with iValid held high: 1..CPS, exact flag high time.
    exp_flag_len = 2 + CPS * STEP;
    x0 = xfer_cnt;
    d0 = done_cnt;
    start_session();
    check("t1_busy", busy, 1'b1);
    check("t1_flag", flag, 1'b1);
    for (int i = 0; i < CPS; i++) send(i, 16'(i + 1), 0);
    valid = 1'b0;
    wait_done("t1_done");
    tick();
    exp_flag_len = 0;
    check("t1_xfers", xfer_cnt - x0, CPS);
    check("t1_done_cnt", done_cnt - d0, 1);
    check("t1_queue", exp_q.size(), 0);
    check("t1_busy_end", busy, 1'b0);

    // Random iValid gaps of 0-5 cycles.
    x0 = xfer_cnt;
    d0 = done_cnt;
    start_session();
    for (int i = 0; i < CPS; i++) send(i, 16'h0100 + 16'(i), $urandom_range(0, 5));
    valid = 1'b0;
    wait_done("t2_done");
    tick();
    check("t2_xfers", xfer_cnt - x0, CPS);
    check("t2_done_cnt", done_cnt - d0, 1);
    check("t2_queue", exp_q.size(), 0);

    // iStart pulses in WRITE, WAIT, and from the last write until DONE.
    d0 = done_cnt;
    start_session();
    for (int i = 0; i < CPS; i++) begin
      send(i, 16'h0200 + 16'(i), 0);
      if (i == 3) begin
        valid = 1'b0;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
      end
    end
    valid = 1'b0;
    start = 1'b1;
    n = 0;
    while (!done && n < LIMIT) begin
      tick();
      n++;
    end
    start = 1'b0;
    check("t3_done", done, 1'b1);
    repeat (10) tick();
    check("t3_done_cnt", done_cnt - d0, 1);
    check("t3_busy", busy, 1'b0);
    check("t3_flag", flag, 1'b0);
    check("t3_queue", exp_q.size(), 0);

    // Reset in the middle of a session, right after a write strobe.
    d0 = done_cnt;
    start_session();
    for (int i = 0; i < ABORT_N; i++) send(i, 16'h0300 + 16'(i), 0);
    valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    tick();
    check("t4_flag", flag, 1'b0);
    check("t4_csn", csn, 1'b1);
    check("t4_busy", busy, 1'b0);
    check("t4_addr", addr, 6'd0);
    check("t4_ready", ready, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    tick();
    check("t4_done_cnt", done_cnt - d0, 0);

    // iStart together with a valid word: that word must not be taken.
    x0 = xfer_cnt;
    d0 = done_cnt;
    start = 1'b1;
    valid = 1'b1;
    coeff = 16'hABCD;
    tick();
    start = 1'b0;
    check("t5_ready_setup", ready, 1'b0);
    n = 0;
    while (!ready && n < LIMIT) begin
      tick();
      n++;
    end
    send(0, 16'h1111, 0);
    for (int i = 1; i < CPS; i++) send(i, 16'h1200 + 16'(i), 0);
    valid = 1'b0;
    wait_done("t5_done");
    tick();
    check("t5_xfers", xfer_cnt - x0, CPS);
    check("t5_done_cnt", done_cnt - d0, 1);
    check("t5_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
